// File: rtl/orientation_sched_pkg.sv
// Shared types and constants for the SIFT orientation MUX scheduler.
// Holds the FSM state enum, histogram bin counts and the watchdog width helper.
package orientation_sched_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT_LO = 2'd1,
      WAIT_HI = 2'd2
   } state_t;

   localparam int NUM_BINS      = 36;
   localparam int NUM_PAIR_BINS = 72;

   // Counter must be able to hold DONE_TIMEOUT itself.
   function automatic int wd_width(input int t);
      return $clog2(t + 1);
   endfunction

endpackage

// File: rtl/orientation_mux_scheduler_done_watchdog.sv
// Watchdog for the peak-finder done handshake.
// Ports: iclk, ireset (async, active-low), i_clr (restart on issue),
//        i_en (count while waiting), o_expire (limit reached this cycle).
module done_watchdog
   import orientation_sched_pkg::*;
#(
   parameter int DONE_TIMEOUT = 255
) (
   input  logic iclk,
   input  logic ireset,
   input  logic i_clr,
   input  logic i_en,
   output logic o_expire
);

   localparam int CNT_W = wd_width(DONE_TIMEOUT);
   // The count is 0 in the first WAIT cycle, so the last WAIT cycle
   // of a full window holds DONE_TIMEOUT-1.
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(DONE_TIMEOUT - 1);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge iclk or negedge ireset) begin
      if (!ireset) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_en) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_expire = i_en && (r_cnt == LIMIT);

endmodule

// File: rtl/orientation_mux_scheduler.sv
// Steers the 72->36 orientation MUX so each valid histogram half of a
// keypoint pair reaches the peak finder once, then acknowledges the pair.
// Ports: iclk, ireset (async, active-low); ipair_valid/ikp_mask/ikp_id0/
//        ikp_id1 from histogram accumulation; ipeak_done from peak finder;
//        oselect_MUX/omux_en/okp_id to the MUX; opair_ack upstream;
//        otimeout watchdog pulse; obusy when not IDLE. All registered.
module orientation_mux_scheduler
   import orientation_sched_pkg::*;
#(
   parameter int ID_W         = 16,
   parameter int DONE_TIMEOUT = 255
) (
   input  logic            iclk,
   input  logic            ireset,
   input  logic            ipair_valid,
   input  logic [1:0]      ikp_mask,
   input  logic [ID_W-1:0] ikp_id0,
   input  logic [ID_W-1:0] ikp_id1,
   input  logic            ipeak_done,
   output logic            oselect_MUX,
   output logic            omux_en,
   output logic [ID_W-1:0] okp_id,
   output logic            opair_ack,
   output logic            otimeout,
   output logic            obusy
);

   state_t          r_state;
   state_t          w_state_nxt;
   logic            r_hi_pend;
   logic [ID_W-1:0] r_id1;
   logic            r_sel;
   logic            r_mux_en;
   logic [ID_W-1:0] r_id;
   logic            r_ack;
   logic            r_timeout;

   logic            w_accept;
   logic            w_done;
   logic            w_expire;
   logic            w_adv;
   logic            w_issue;
   logic            w_sel_nxt;
   logic [ID_W-1:0] w_id_nxt;
   logic            w_ack_nxt;
   logic            w_to_nxt;
   logic            w_wait;

   // The ack cycle is never an accept cycle, even with valid still high.
   assign w_accept = (r_state == IDLE) && ipair_valid && !r_ack;
   // A done coinciding with the issue pulse belongs to the previous job.
   assign w_done   = ipeak_done && !r_mux_en;
   assign w_adv    = w_done || w_expire;
   assign w_wait   = (r_state != IDLE);

   done_watchdog #(
      .DONE_TIMEOUT(DONE_TIMEOUT)
   ) u_wd (
      .iclk     (iclk),
      .ireset   (ireset),
      .i_clr    (w_issue),
      .i_en     (w_wait),
      .o_expire (w_expire)
   );

   always_ff @(posedge iclk or negedge ireset) begin
      if (!ireset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_issue     = 1'b0;
      w_sel_nxt   = r_sel;
      w_id_nxt    = r_id;
      w_ack_nxt   = 1'b0;
      w_to_nxt    = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (w_accept) begin
               if (ikp_mask[0]) begin
                  w_state_nxt = WAIT_LO;
                  w_issue     = 1'b1;
                  w_sel_nxt   = 1'b1;
                  w_id_nxt    = ikp_id0;
               end else if (ikp_mask[1]) begin
                  w_state_nxt = WAIT_HI;
                  w_issue     = 1'b1;
                  w_sel_nxt   = 1'b0;
                  w_id_nxt    = ikp_id1;
               end else begin
                  w_ack_nxt   = 1'b1;
               end
            end
         end
         WAIT_LO: begin
            if (w_adv) begin
               w_to_nxt = !w_done;
               if (r_hi_pend) begin
                  w_state_nxt = WAIT_HI;
                  w_issue     = 1'b1;
                  w_sel_nxt   = 1'b0;
                  w_id_nxt    = r_id1;
               end else begin
                  w_state_nxt = IDLE;
                  w_ack_nxt   = 1'b1;
               end
            end
         end
         WAIT_HI: begin
            if (w_adv) begin
               w_to_nxt    = !w_done;
               w_state_nxt = IDLE;
               w_ack_nxt   = 1'b1;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge iclk or negedge ireset) begin
      if (!ireset) begin
         r_hi_pend <= 1'b0;
         r_id1     <= '0;
         r_sel     <= 1'b0;
         r_mux_en  <= 1'b0;
         r_id      <= '0;
         r_ack     <= 1'b0;
         r_timeout <= 1'b0;
      end else begin
         if (w_accept) begin
            r_hi_pend <= ikp_mask[1];
            r_id1     <= ikp_id1;
         end
         r_sel     <= w_sel_nxt;
         r_mux_en  <= w_issue;
         r_id      <= w_id_nxt;
         r_ack     <= w_ack_nxt;
         r_timeout <= w_to_nxt;
      end
   end

   assign oselect_MUX = r_sel;
   assign omux_en     = r_mux_en;
   assign okp_id      = r_id;
   assign opair_ack   = r_ack;
   assign otimeout    = r_timeout;
   assign obusy       = (r_state != IDLE);

endmodule

// File: tb/tb_orientation_mux_scheduler.sv
// Scoreboard bench for orientation_mux_scheduler: a cycle-level event model
// predicts every issue/timeout/ack, a negedge monitor compares.
module tb_orientation_mux_scheduler;

   localparam int DT = 8;

   logic        iclk = 1'b0;
   logic        ireset = 1'b0;
   logic        ipair_valid = 1'b0;
   logic [1:0]  ikp_mask = '0;
   logic [15:0] ikp_id0 = '0;
   logic [15:0] ikp_id1 = '0;
   logic        ipeak_done = 1'b0;
   logic        oselect_MUX;
   logic        omux_en;
   logic [15:0] okp_id;
   logic        opair_ack;
   logic        otimeout;
   logic        obusy;

   typedef struct {
      int          cyc;
      bit          en;
      bit          ack;
      bit          to;
      bit          sel;
      logic [15:0] id;
   } ev_t;

   ev_t         sb[$];
   int          cyc = 0;
   int          total = 0;
   int          bad = 0;
   int          last_ack = 0;
   bit          last_sel = 1'b0;
   logic [15:0] last_id = '0;

   orientation_mux_scheduler #(
      .ID_W(16),
      .DONE_TIMEOUT(DT)
   ) dut (
      .iclk        (iclk),
      .ireset      (ireset),
      .ipair_valid (ipair_valid),
      .ikp_mask    (ikp_mask),
      .ikp_id0     (ikp_id0),
      .ikp_id1     (ikp_id1),
      .ipeak_done  (ipeak_done),
      .oselect_MUX (oselect_MUX),
      .omux_en     (omux_en),
      .okp_id      (okp_id),
      .opair_ack   (opair_ack),
      .otimeout    (otimeout),
      .obusy       (obusy)
   );

   always #5 iclk = ~iclk;

   always @(posedge iclk) cyc <= cyc + 1;

   initial begin
      #2000000;
      $display("FAIL global_time_limit cycle=%0d", cyc);
      $fatal(1);
   end

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                  nm, act, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge iclk);
      #1;
   endtask

   // Same-cycle events (timeout with next issue or ack) merge into one.
   function automatic void push_ev(input int c, input bit en,
                                   input bit ack, input bit to,
                                   input bit sel, input logic [15:0] id);
      ev_t r;
      if (sb.size() > 0 && sb[sb.size()-1].cyc == c) begin
         r = sb.pop_back();
         r.en  = r.en | en;
         r.ack = r.ack | ack;
         r.to  = r.to | to;
         if (en) begin
            r.sel = sel;
            r.id  = id;
         end
      end else begin
         r.cyc = c;
         r.en  = en;
         r.ack = ack;
         r.to  = to;
         r.sel = sel;
         r.id  = id;
      end
      sb.push_back(r);
   endfunction

   always @(negedge iclk) begin
      ev_t e;
      if (ireset) begin
         while (sb.size() > 0 && sb[0].cyc < cyc) begin
            chk("missed_event_cycle", cyc, sb[0].cyc);
            void'(sb.pop_front());
         end
         if (omux_en || opair_ack || otimeout) begin
            if (sb.size() == 0) begin
               chk("unexpected_event_cycle", cyc, -1);
            end else begin
               e = sb.pop_front();
               chk("event_cycle", cyc, e.cyc);
               chk("omux_en", int'(omux_en), int'(e.en));
               chk("opair_ack", int'(opair_ack), int'(e.ack));
               chk("otimeout", int'(otimeout), int'(e.to));
               chk("obusy", int'(obusy), int'(e.en));
               chk("oselect_MUX", int'(oselect_MUX), int'(e.sel));
               chk("okp_id", int'(okp_id), int'(e.id));
            end
         end
      end
   end

   // d in 1..DT-1: done d cycles after the issue pulse; otherwise no done.
   // spur: extra done during the issue pulse, which must be ignored.
   task automatic run_pair(input bit [1:0] m, input logic [15:0] i0,
                           input logic [15:0] i1, input int gap,
                           input int dlo, input int dhi,
                           input bit slo, input bit shi);
      int p, a, t, e, d, ack_c;
      int dq[$];
      bit hit;
      p = cyc + gap;
      a = (p > last_ack) ? p : last_ack + 1;
      if (m == 2'b00) begin
         ack_c = a + 1;
         push_ev(ack_c, 0, 1, 0, last_sel, last_id);
      end else begin
         t = a;
         for (int k = 0; k < 2; k++) begin
            if (m[k]) begin
               e = t + 1;
               d = (k == 0) ? dlo : dhi;
               last_sel = (k == 0);
               last_id  = (k == 0) ? i0 : i1;
               push_ev(e, 1, 0, 0, last_sel, last_id);
               if ((k == 0) ? slo : shi) dq.push_back(e);
               if (d >= 1 && d <= DT - 1) begin
                  dq.push_back(e + d);
                  t = e + d;
               end else begin
                  t = e + DT - 1;
                  push_ev(t + 1, 0, 0, 1, last_sel, last_id);
               end
            end
         end
         ack_c = t + 1;
         push_ev(ack_c, 0, 1, 0, last_sel, last_id);
      end
      while (cyc < ack_c) begin
         ipair_valid = (cyc >= p);
         if (cyc >= p) begin
            ikp_mask = m;
            ikp_id0  = i0;
            ikp_id1  = i1;
         end else begin
            ikp_mask = 2'($urandom);
            ikp_id0  = 16'($urandom);
            ikp_id1  = 16'($urandom);
         end
         hit = 1'b0;
         foreach (dq[j]) if (dq[j] == cyc) hit = 1'b1;
         // Stray dones while idle must have no effect.
         ipeak_done = hit || (cyc <= a && $urandom_range(0, 3) == 0);
         step();
      end
      last_ack = ack_c;
   endtask

   initial begin
      int a;
      int dl;
      int dh;
      ireset = 1'b0;
      repeat (3) step();
      chk("rst_omux_en", int'(omux_en), 0);
      chk("rst_oselect", int'(oselect_MUX), 0);
      chk("rst_okp_id", int'(okp_id), 0);
      chk("rst_opair_ack", int'(opair_ack), 0);
      chk("rst_otimeout", int'(otimeout), 0);
      chk("rst_obusy", int'(obusy), 0);
      ireset   = 1'b1;
      last_ack = cyc - 1;

      run_pair(2'b11, 16'h0011, 16'h0022, 0, 5, 5, 0, 0);
      run_pair(2'b10, 16'h0000, 16'h00AB, 1, 0, 4, 0, 0);
      run_pair(2'b00, 16'h1234, 16'h5678, 2, 0, 0, 0, 0);
      run_pair(2'b01, 16'h0033, 16'h0000, 0, -1, 0, 0, 0);
      run_pair(2'b01, 16'h0044, 16'h0000, 0, DT - 1, 0, 0, 0);
      run_pair(2'b11, 16'h0055, 16'h0066, 1, 3, -1, 1, 1);
      run_pair(2'b11, 16'h0077, 16'h0088, 0, -1, DT - 1, 0, 1);
      run_pair(2'b00, 16'h0099, 16'h00AA, 0, 0, 0, 0, 0);

      for (int n = 0; n < 150; n++) begin
         dl = $urandom_range(1, DT + 2);
         dh = $urandom_range(1, DT + 2);
         if (dl > DT - 1) dl = -1;
         if (dh > DT - 1) dh = -1;
         run_pair(2'($urandom), 16'($urandom), 16'($urandom),
                  int'($urandom_range(0, 2)), dl, dh,
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      // Reset while waiting on the upper half, valid held throughout.
      a = (cyc > last_ack) ? cyc : last_ack + 1;
      ipair_valid = 1'b1;
      ikp_mask    = 2'b10;
      ikp_id0     = 16'h0000;
      ikp_id1     = 16'h5A5A;
      ipeak_done  = 1'b0;
      push_ev(a + 1, 1, 0, 0, 1'b0, 16'h5A5A);
      while (cyc < a + 3) step();
      ireset = 1'b0;
      #1;
      chk("midrst_omux_en", int'(omux_en), 0);
      chk("midrst_oselect", int'(oselect_MUX), 0);
      chk("midrst_okp_id", int'(okp_id), 0);
      chk("midrst_opair_ack", int'(opair_ack), 0);
      chk("midrst_otimeout", int'(otimeout), 0);
      chk("midrst_obusy", int'(obusy), 0);
      step();
      step();
      chk("inrst_opair_ack", int'(opair_ack), 0);
      chk("inrst_obusy", int'(obusy), 0);
      chk("inrst_sb_drained", sb.size(), 0);
      last_sel = 1'b0;
      last_id  = '0;
      ireset   = 1'b1;
      last_ack = cyc - 1;
      run_pair(2'b10, 16'h0000, 16'h5A5A, 0, 0, 3, 0, 0);

      ipair_valid = 1'b0;
      ipeak_done  = 1'b0;
      repeat (5) step();
      chk("scoreboard_empty", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/orientation_mux_scheduler.md
# orientation_mux_scheduler

Sequences the 72→36 statistics-orientation MUX in the SIFT dominant-orientation path. Upstream histogram accumulation presents a pair of keypoint histograms (bins 0–35 for keypoint 0, bins 36–71 for keypoint 1). This block steers the MUX select and data enable so each valid half reaches the dominant-orientation peak finder exactly once. It waits for the peak finder's done, or a watchdog timeout, before issuing the next half, then acknowledges the pair upstream.

## Interface
Parameters:
- ID_W, 16, keypoint tag width.
- DONE_TIMEOUT, 255, maximum WAIT cycles before forced advance; must be ≥ 2.

Ports:
- iclk  in  1  clock
- ireset  in  1  reset, asynchronous, active-low
- ipair_valid  in  1  pair of histograms stable on MUX inputs; held with ikp_mask/ids until opair_ack
- ikp_mask  in  2  bit0: lower half valid keypoint; bit1: upper half valid keypoint
- ikp_id0  in  ID_W  tag of lower-half keypoint
- ikp_id1  in  ID_W  tag of upper-half keypoint
- ipeak_done  in  1  peak finder finished current histogram (single-cycle pulse)
- oselect_MUX  out  1  MUX select; 1 = bins 0–35, 0 = bins 36–71
- omux_en  out  1  MUX data enable, one-cycle pulse per issued half
- okp_id  out  ID_W  tag of histogram currently being processed
- opair_ack  out  1  one-cycle pulse: pair consumed, upstream may change inputs
- otimeout  out  1  one-cycle pulse: WAIT expired without ipeak_done
- obusy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, WAIT_LO, WAIT_HI. Mask, ids latched at accept.
- IDLE, ipair_valid=1, not ack cycle:
  - mask[0]=1 → WAIT_LO; next cycle omux_en=1, oselect_MUX=1, okp_id=id0.
  - mask=10 → WAIT_HI; omux_en=1, oselect_MUX=0, okp_id=id1.
  - mask=00 → stay IDLE; opair_ack=1 next cycle; no omux_en.
- WAIT_LO: hold oselect_MUX=1. On done or timeout: mask[1]=1 → WAIT_HI, issuing as above. Otherwise → IDLE with opair_ack.
- WAIT_HI: hold oselect_MUX=0. On done or timeout → IDLE with opair_ack.
- Done condition: ipeak_done sampled only in WAIT states and only in cycles where omux_en=0. A done coinciding with the omux_en pulse is ignored.
- Watchdog:
  - Counter clears on each issue and increments every WAIT cycle.
  - When it reaches DONE_TIMEOUT without done, otimeout pulses and the FSM advances as if done.
  - ipeak_done and expiry in the same cycle: treated as done, no otimeout.
- In the cycle opair_ack=1, ipair_valid is ignored. A still-high ipair_valid in the following cycle is a new pair.
- oselect_MUX and okp_id hold their last values in IDLE.

## Timing
- All outputs are registered. Reset values: oselect_MUX=0, omux_en=0, okp_id=0, opair_ack=0, otimeout=0, obusy=0; FSM=IDLE; watchdog=0.
- Accept edge k; omux_en high in cycle k+1; the MUX registered output and its odata_en appear in cycle k+2.
- Lower→upper handover: the done edge issues the upper half; omux_en is high the next cycle with no idle gap.
- opair_ack is high in the cycle after the final done or timeout edge. The earliest next accept is the edge ending the ack cycle + 1.
- Minimum pair period, mask=11: 2 issue cycles + 2 done latencies + 1 ack cycle.
- Reset mid-operation: immediate return to reset values. The pending pair is dropped without ack, and upstream re-presents it.

## Structure
- Package orientation_sched_pkg:
  - state enum (IDLE, WAIT_LO, WAIT_HI)
  - constants NUM_BINS=36, NUM_PAIR_BINS=72
  - localparam function for watchdog width, $clog2(DONE_TIMEOUT+1)
- One sub-module, done_watchdog: clear, enable, expire outputs, parameterised by DONE_TIMEOUT. The FSM lives in the top.

## Test plan
- Mask=11, id0=0x0011, id1=0x0022; ipeak_done 5 cycles after each omux_en.
  - Response: omux_en pulses with sel=1/id 0x0011, then sel=0/id 0x0022; one opair_ack; otimeout never.
- Mask=10, id1=0x00AB:
  - Response: single omux_en with sel=0, okp_id=0x00AB; ack after done.
- Mask=00:
  - Response: opair_ack one cycle after accept; omux_en stays 0; obusy stays 0.
- DONE_TIMEOUT=8, mask=01, no ipeak_done:
  - Response: otimeout pulses after 8 WAIT cycles, then opair_ack.
  - Repeat with done and expiry in the same cycle: no otimeout.
- ipeak_done asserted during the omux_en pulse:
  - Response: ignored; FSM stays in WAIT until a later done.
- Reset asserted in WAIT_HI, ipair_valid held high:
  - Response: all outputs 0 immediately, no ack.
  - After release: re-accept, and omux_en appears 1 cycle later.
